mem_access: RTL and testbench

- Memory stage of the 5-stage core; sits between EX_MEM and MEM_WB.
- Takes the ALU result, store data and MEM/WB control from EX_MEM, then runs loads/stores on the data-memory port with a req/ack handshake.
- Handles byte/half lane steering, sign/zero extension and misalignment detection.
- Drives the MEM_WB inputs and stalls upstream while an access is in flight.

---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/mem_align.sv | 77 +++++++
 rtl/mem_access.sv | 129 ++++++++++++
 tb/tb_mem_access.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory stage: widths, control field positions,
// funct3 encodings and the access FSM state type.
package mem_access_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REGS_W    = 5;
  localparam int unsigned WB_CTRL_W = 2;
  localparam int unsigned CTRL_W    = 5;
  localparam int unsigned STRB_W    = DATA_W / 8;

  // Field positions inside MEM_ctrl_in = {mem_read, mem_write, funct3}
  localparam int unsigned CTRL_RD_BIT = 4;
  localparam int unsigned CTRL_WR_BIT = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for stores, load extraction/extension, and the
// misaligned/illegal access check.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  input  logic              is_read,
  input  logic              is_write,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              fault,
  input  logic [1:0]        ld_addr_lo,
  input  logic [2:0]        ld_funct3,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store data replication and byte strobes
  always_comb begin
    wdata = store_data;
    wstrb = '0;
    if (is_write) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << addr_lo;
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        end
        F3_SW:   wstrb = 4'b1111;
        default: wstrb = '0;
      endcase
    end
  end

  // Unsupported funct3 values are reported through the same flag as misalignment
  always_comb begin
    fault = 1'b0;
    if (is_read) begin
      case (funct3)
        F3_LB, F3_LBU: fault = 1'b0;
        F3_LH, F3_LHU: fault = addr_lo[0];
        F3_LW:         fault = |addr_lo;
        default:       fault = 1'b1;
      endcase
    end else if (is_write) begin
      case (funct3)
        F3_SB:   fault = 1'b0;
        F3_SH:   fault = addr_lo[0];
        F3_SW:   fault = |addr_lo;
        default: fault = 1'b1;
      endcase
    end
  end

  assign ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata;
    case (ld_funct3)
      F3_LB:   load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_LH:   load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: issues loads/stores on the req/ack data-memory port,
// stalls upstream while an access is in flight and feeds MEM_WB.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    addr_in,
  input  logic [DATA_W-1:0]    store_data_in,
  input  logic [DATA_W-1:0]    pc_4_in,
  input  logic [REGS_W-1:0]    rd_in,
  input  logic [CTRL_W-1:0]    MEM_ctrl_in,
  input  logic [WB_CTRL_W-1:0] WB_ctrl_in,
  output logic [DATA_W-1:0]    addr_out,
  output logic [DATA_W-1:0]    data_out,
  output logic [DATA_W-1:0]    pc_4_out,
  output logic [REGS_W-1:0]    rd_out,
  output logic [WB_CTRL_W-1:0] WB_ctrl_out,
  output logic                 mem_stall,
  output logic                 misalign,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DATA_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]    dmem_wdata,
  output logic [STRB_W-1:0]    dmem_wstrb,
  input  logic [DATA_W-1:0]    dmem_rdata,
  input  logic                 dmem_ack
);

  state_t              state;
  logic [DATA_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [STRB_W-1:0]   cap_wstrb;
  logic                cap_we;
  logic [2:0]          cap_f3;
  logic [DATA_W-1:0]   rdata_q;

  logic                is_read;
  logic                is_write;
  logic                has_op;
  logic                fault;
  logic                accept;
  logic [DATA_W-1:0]   st_wdata;
  logic [STRB_W-1:0]   st_wstrb;
  logic [DATA_W-1:0]   ld_data;

  // A simultaneous read+write is treated as a read
  assign is_read  = MEM_ctrl_in[CTRL_RD_BIT];
  assign is_write = MEM_ctrl_in[CTRL_WR_BIT] & ~is_read;
  assign has_op   = is_read | is_write;
  assign accept   = (state == ST_IDLE) & has_op & ~fault;

  mem_align u_align (
    .addr_lo    (addr_in[1:0]),
    .funct3     (MEM_ctrl_in[2:0]),
    .is_read    (is_read),
    .is_write   (is_write),
    .store_data (store_data_in),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .fault      (fault),
    .ld_addr_lo (cap_addr[1:0]),
    .ld_funct3  (cap_f3),
    .rdata      (dmem_rdata),
    .load_data  (ld_data)
  );

  // Access FSM with capture of the request fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      cap_we    <= 1'b0;
      cap_f3    <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_addr  <= addr_in;
            cap_wdata <= st_wdata;
            cap_wstrb <= st_wstrb;
            cap_we    <= is_write;
            cap_f3    <= MEM_ctrl_in[2:0];
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            rdata_q <= cap_we ? '0 : ld_data;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port driven from captured fields so they hold stable until ack
  assign dmem_req   = (state == ST_BUSY);
  assign dmem_we    = dmem_req & cap_we;
  assign dmem_wstrb = dmem_req ? cap_wstrb : '0;
  assign dmem_addr  = {cap_addr[DATA_W-1:2], 2'b00};
  assign dmem_wdata = cap_wdata;

  // Stall is gated by reset so it drops immediately even with an op still held
  assign mem_stall = rst & (accept | (state == ST_BUSY));
  assign misalign  = (state == ST_IDLE) & has_op & fault;

  assign addr_out = addr_in;
  assign pc_4_out = pc_4_in;
  assign rd_out   = rd_in;

  // Writeback control is squashed into a bubble until the result is presented
  always_comb begin
    WB_ctrl_out = WB_ctrl_in;
    data_out    = '0;
    case (state)
      ST_IDLE: if (has_op) WB_ctrl_out = '0;
      ST_BUSY: WB_ctrl_out = '0;
      ST_DONE: data_out = rdata_q;
      default: WB_ctrl_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset-abort sequence
// and randomized accesses checked against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    addr_in, store_data_in, pc_4_in;
  logic [REGS_W-1:0]    rd_in;
  logic [CTRL_W-1:0]    MEM_ctrl_in;
  logic [WB_CTRL_W-1:0] WB_ctrl_in;
  logic [DATA_W-1:0]    addr_out, data_out, pc_4_out;
  logic [REGS_W-1:0]    rd_out;
  logic [WB_CTRL_W-1:0] WB_ctrl_out;
  logic                 mem_stall, misalign, dmem_req, dmem_we;
  logic [DATA_W-1:0]    dmem_addr, dmem_wdata, dmem_rdata;
  logic [STRB_W-1:0]    dmem_wstrb;
  logic                 dmem_ack;

  int n_pass  = 0;
  int n_total = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .store_data_in(store_data_in),
    .pc_4_in(pc_4_in), .rd_in(rd_in), .MEM_ctrl_in(MEM_ctrl_in), .WB_ctrl_in(WB_ctrl_in),
    .addr_out(addr_out), .data_out(data_out), .pc_4_out(pc_4_out), .rd_out(rd_out),
    .WB_ctrl_out(WB_ctrl_out), .mem_stall(mem_stall), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          d;
    logic [1:0]  wb;
    logic        exp_op;
    logic        exp_fault;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int d, input logic [1:0] wb,
                              input logic op, input logic flt, input logic we, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] data);
    vec_t v;
    v.ctrl = ctrl; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.d = d; v.wb = wb;
    v.exp_op = op; v.exp_fault = flt; v.exp_we = we; v.exp_wstrb = strb;
    v.exp_wdata = wdata; v.exp_data = data;
    return v;
  endfunction

  // Reference model: access size from funct3, lanes and extension by plain arithmetic
  function automatic vec_t model(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int d, input logic [1:0] wb);
    vec_t v;
    bit rd_op, wr_op;
    int f3, lo, size;
    logic [63:0] val;
    v = mk(ctrl, addr, sdata, rdata, d, wb, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rd_op = ctrl[4];
    wr_op = ctrl[3] && !ctrl[4];
    f3 = int'(ctrl[2:0]);
    lo = int'(addr % 4);
    v.exp_op = rd_op || wr_op;
    v.exp_we = wr_op;
    if (rd_op) begin
      if (f3 == 3 || f3 >= 6) v.exp_fault = 1'b1;
      else begin
        size = 1 << (f3 % 4);
        if (lo % size != 0) v.exp_fault = 1'b1;
        else begin
          val = ({32'h0, rdata} >> (8 * lo)) % (64'd1 << (8 * size));
          if (f3 < 4 && size < 4 && val >= (64'd1 << (8 * size - 1)))
            val = val + (64'd1 << 32) - (64'd1 << (8 * size));
          v.exp_data = val[31:0];
        end
      end
    end else if (wr_op) begin
      if (f3 >= 3) v.exp_fault = 1'b1;
      else begin
        size = 1 << f3;
        if (lo % size != 0) v.exp_fault = 1'b1;
        else begin
          v.exp_wstrb = 4'(((1 << size) - 1) << lo);
          for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
        end
      end
    end
    return v;
  endfunction

  // Drives one op at a negedge and walks it through accept, BUSY and DONE
  task automatic run_access(input vec_t v, input bit early_ack);
    logic [31:0] pc;
    logic [4:0]  rd;
    pc = $urandom;
    rd = 5'($urandom);
    @(negedge clk);
    MEM_ctrl_in = v.ctrl; addr_in = v.addr; store_data_in = v.sdata; dmem_rdata = v.rdata;
    WB_ctrl_in = v.wb; pc_4_in = pc; rd_in = rd; dmem_ack = early_ack;
    #1;
    chk("addr_out", addr_out, v.addr);
    chk("pc_4_out", pc_4_out, pc);
    chk("rd_out", 32'(rd_out), 32'(rd));
    if (!v.exp_op) begin
      chk("idle_misalign", 32'(misalign), 32'h0);
      chk("idle_stall", 32'(mem_stall), 32'h0);
      chk("idle_req", 32'(dmem_req), 32'h0);
      chk("idle_wb", 32'(WB_ctrl_out), 32'(v.wb));
      chk("idle_data", data_out, 32'h0);
      return;
    end
    if (v.exp_fault) begin
      chk("fault_misalign", 32'(misalign), 32'h1);
      chk("fault_stall", 32'(mem_stall), 32'h0);
      chk("fault_req", 32'(dmem_req), 32'h0);
      chk("fault_wb", 32'(WB_ctrl_out), 32'h0);
      return;
    end
    chk("acc_misalign", 32'(misalign), 32'h0);
    chk("acc_stall", 32'(mem_stall), 32'h1);
    chk("acc_req", 32'(dmem_req), 32'h0);
    chk("acc_wb", 32'(WB_ctrl_out), 32'h0);
    for (int k = 0; k <= v.d; k++) begin
      @(negedge clk);
      dmem_ack = (k == v.d);
      #1;
      chk("busy_req", 32'(dmem_req), 32'h1);
      chk("busy_stall", 32'(mem_stall), 32'h1);
      chk("busy_wb", 32'(WB_ctrl_out), 32'h0);
      chk("busy_addr", dmem_addr, {v.addr[31:2], 2'b00});
      chk("busy_we", 32'(dmem_we), 32'(v.exp_we));
      chk("busy_wstrb", 32'(dmem_wstrb), 32'(v.exp_wstrb));
      if (v.exp_we) chk("busy_wdata", dmem_wdata, v.exp_wdata);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("done_stall", 32'(mem_stall), 32'h0);
    chk("done_req", 32'(dmem_req), 32'h0);
    chk("done_data", data_out, v.exp_data);
    chk("done_wb", 32'(WB_ctrl_out), 32'(v.wb));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [4:0] ctrl;

    rst = 1'b0;
    addr_in = '0; store_data_in = '0; pc_4_in = '0; rd_in = '0;
    MEM_ctrl_in = '0; WB_ctrl_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    #3;
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_data", data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    //          ctrl      addr          sdata         rdata         d  wb     op fl we strb     wdata         data
    tbl.push_back(mk(5'b00000, 32'h0000_0010, 32'h0,         32'h0,         0, 2'b01, 0, 0, 0, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(5'b01000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0,         2, 2'b01, 1, 0, 1, 4'b1000, 32'hDDDD_DDDD, 32'h0));
    tbl.push_back(mk(5'b10000, 32'h0000_2001, 32'h0,         32'h0000_F100, 0, 2'b11, 1, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FFF1));
    tbl.push_back(mk(5'b10100, 32'h0000_2001, 32'h0,         32'h0000_F100, 0, 2'b11, 1, 0, 0, 4'b0000, 32'h0,         32'h0000_00F1));
    tbl.push_back(mk(5'b10001, 32'h0000_2002, 32'h0,         32'h8001_0000, 1, 2'b11, 1, 0, 0, 4'b0000, 32'h0,         32'hFFFF_8001));
    tbl.push_back(mk(5'b10010, 32'h0000_2006, 32'h0,         32'h0,         0, 2'b11, 1, 1, 0, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(5'b10010, 32'h0000_3000, 32'h0,         32'h1234_5678, 1, 2'b10, 1, 0, 0, 4'b0000, 32'h0,         32'h1234_5678));
    tbl.push_back(mk(5'b01010, 32'h0000_3004, 32'hCAFE_BABE, 32'h0,         0, 2'b01, 1, 0, 1, 4'b1111, 32'hCAFE_BABE, 32'h0));
    tbl.push_back(mk(5'b01001, 32'h0000_1002, 32'h0000_BEEF, 32'h0,         1, 2'b01, 1, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    tbl.push_back(mk(5'b10101, 32'h0000_0010, 32'h0,         32'h0000_ABCD, 3, 2'b10, 1, 0, 0, 4'b0000, 32'h0,         32'h0000_ABCD));
    tbl.push_back(mk(5'b10011, 32'h0000_0000, 32'h0,         32'h0,         0, 2'b11, 1, 1, 0, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(5'b01011, 32'h0000_0000, 32'h0,         32'h0,         0, 2'b11, 1, 1, 0, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(5'b11010, 32'h0000_0040, 32'h5555_5555, 32'h1122_3344, 0, 2'b01, 1, 0, 0, 4'b0000, 32'h0,         32'h1122_3344));
    tbl.push_back(mk(5'b01001, 32'h0000_1001, 32'h1234_5678, 32'h0,         0, 2'b01, 1, 1, 0, 4'b0000, 32'h0,         32'h0));
    tbl.push_back(mk(5'b10000, 32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 2'b01, 1, 0, 0, 4'b0000, 32'h0,         32'h0000_007F));

    foreach (tbl[i]) run_access(tbl[i], 1'b0);

    // Reset while BUSY abandons the access; a late ack must not revive it
    @(negedge clk);
    MEM_ctrl_in = 5'b10000; addr_in = 32'h0000_2001; dmem_rdata = 32'h0000_F100;
    WB_ctrl_in = 2'b01; dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(dmem_req), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(dmem_req), 32'h0);
    chk("async_rst_stall", 32'(mem_stall), 32'h0);
    chk("async_rst_wstrb", 32'(dmem_wstrb), 32'h0);
    chk("async_rst_dmem_addr", dmem_addr, 32'h0);
    MEM_ctrl_in = 5'b00000;
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(dmem_req), 32'h0);
    chk("late_ack_stall", 32'(mem_stall), 32'h0);
    chk("late_ack_data", data_out, 32'h0);
    chk("late_ack_wb", 32'(WB_ctrl_out), 32'h1);

    for (int n = 0; n < 250; n++) begin
      ctrl = 5'($urandom);
      if ($urandom_range(0, 9) < 2) ctrl[4:3] = 2'b00;
      else if ($urandom_range(0, 9) < 7) ctrl[2:0] = 3'($urandom_range(0, 2)) | (ctrl[4] ? {ctrl[2], 2'b00} : 3'b000);
      v = model(ctrl, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 2'($urandom));
      run_access(v, 1'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
